box_drawer: RTL and testbench

//   Downstream stage of the box register. Redraws the player box on the VGA framebuffer once per game tick.

---
 rtl/box_drawer.sv | 172 +++++++++++++++++
 tb/tb_box_drawer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/box_drawer.sv
// box_drawer: redraws the player box on the VGA framebuffer once per game tick.
// Each frame erases the box at its previous row (unless unchanged), then draws
// it at the new row, one pixel per clock in raster order.
//
// Ports
//   clk          system clock, rising-edge
//   resetn       asynchronous active-low reset
//   tick         one-cycle redraw request
//   y_coordinate box top row, sampled in START
//   x_out/y_out  pixel position to the VGA adapter
//   colour       pixel colour
//   plot         write enable (x_out/y_out/colour valid only while high)
//   busy         frame in progress
//   done         one-cycle pulse at the end of each frame
//
// state  | meaning
// IDLE   | waiting for tick
// START  | sample and clamp y, clear pixel counters
// ERASE  | plot background over the old box
// DRAW   | plot box colour at the new position
// FIN    | done pulse, commit new row, restart if a tick was queued
module box_drawer #(
    parameter logic [7:0] BOX_X      = 8'd20,
    parameter int         BOX_SIZE   = 4,
    parameter logic [6:0] SCREEN_H   = 7'd120,
    parameter logic [2:0] BOX_COLOUR = 3'b110,
    parameter logic [2:0] BG_COLOUR  = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic [6:0] y_coordinate,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ERASE, S_DRAW, S_FIN
    } state_t;

    localparam logic [3:0] LAST  = 4'(BOX_SIZE - 1);
    localparam logic [6:0] Y_MAX = SCREEN_H - 7'(BOX_SIZE);
    localparam logic [6:0] Y_RST = 7'd60;

    state_t     state_q, state_d;
    logic [3:0] px_q, px_d, py_q, py_d;
    logic       pending_q, pending_d;
    logic [6:0] old_y_q, old_y_d, new_y_q, new_y_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic [6:0] y_clamped;
    logic       pix_last;

    assign y_clamped = (y_coordinate > Y_MAX) ? Y_MAX : y_coordinate;
    assign pix_last  = (px_q == LAST) && (py_q == LAST);

    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        pending_d = pending_q;
        old_y_d   = old_y_q;
        new_y_d   = new_y_q;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;
        done_d    = 1'b0;
        // Outputs trail the state by one register stage, so busy covers the
        // done cycle produced while the state is FIN.
        busy_d    = (state_q != S_IDLE);

        // Shared raster stepping for ERASE and DRAW
        if (state_q == S_ERASE || state_q == S_DRAW) begin
            if (pix_last) begin
                px_d = 4'd0;
                py_d = 4'd0;
            end else if (px_q == LAST) begin
                px_d = 4'd0;
                py_d = py_q + 4'd1;
            end else begin
                px_d = px_q + 4'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (tick) state_d = S_START;
            end
            S_START: begin
                if (tick) pending_d = 1'b1;
                new_y_d = y_clamped;
                px_d    = 4'd0;
                py_d    = 4'd0;
                state_d = (y_clamped == old_y_q) ? S_DRAW : S_ERASE;
            end
            S_ERASE: begin
                if (tick) pending_d = 1'b1;
                plot_d   = 1'b1;
                x_d      = BOX_X + {4'b0, px_q};
                y_d      = old_y_q + {3'b0, py_q};
                colour_d = BG_COLOUR;
                if (pix_last) state_d = S_DRAW;
            end
            S_DRAW: begin
                if (tick) pending_d = 1'b1;
                plot_d   = 1'b1;
                x_d      = BOX_X + {4'b0, px_q};
                y_d      = new_y_q + {3'b0, py_q};
                colour_d = BOX_COLOUR;
                if (pix_last) state_d = S_FIN;
            end
            S_FIN: begin
                done_d  = 1'b1;
                old_y_d = new_y_q;
                // A tick landing in FIN itself is also queued rather than lost.
                if (pending_q || tick) begin
                    pending_d = 1'b0;
                    state_d   = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            px_q      <= 4'd0;
            py_q      <= 4'd0;
            pending_q <= 1'b0;
            old_y_q   <= Y_RST;
            new_y_q   <= Y_RST;
            x_q       <= 8'd0;
            y_q       <= 7'd0;
            colour_q  <= 3'd0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pending_q <= pending_d;
            old_y_q   <= old_y_d;
            new_y_q   <= new_y_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x_out  = x_q;
    assign y_out  = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_box_drawer.sv
// Directed bench for box_drawer: frame timing, erase/draw raster contents,
// row clamp, tick queuing, async reset and a randomized soak.
module tb_box_drawer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tick = 1'b0;
    logic [6:0] y_coordinate = 7'd60;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot, busy, done;

    int total = 0;
    int bad   = 0;

    box_drawer dut (
        .clk          (clk),
        .resetn       (resetn),
        .tick         (tick),
        .y_coordinate (y_coordinate),
        .x_out        (x_out),
        .y_out        (y_out),
        .colour       (colour),
        .plot         (plot),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Leaves the caller at the negedge after the edge that sampled tick.
    task automatic tick_pulse();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    // Checks from the START output cycle through the done cycle.
    task automatic frame_body(input bit erase, input logic [6:0] oy, input logic [6:0] ny);
        @(negedge clk);
        check("start_plot", plot, 1'b0);
        check("start_busy", busy, 1'b1);
        check("start_done", done, 1'b0);
        if (erase) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                check("erase_plot", plot, 1'b1);
                check("erase_x", x_out, 8'(20 + i % 4));
                check("erase_y", y_out, 7'(oy + 7'(i / 4)));
                check("erase_col", colour, 3'b000);
                check("erase_busy", busy, 1'b1);
            end
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("draw_plot", plot, 1'b1);
            check("draw_x", x_out, 8'(20 + i % 4));
            check("draw_y", y_out, 7'(ny + 7'(i / 4)));
            check("draw_col", colour, 3'b110);
            check("draw_ymax", (y_out <= 7'd119), 1'b1);
            check("draw_done", done, 1'b0);
        end
        @(negedge clk);
        check("fin_done", done, 1'b1);
        check("fin_plot", plot, 1'b0);
        check("fin_busy", busy, 1'b1);
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);
        check("idle_plot", plot, 1'b0);
    endtask

    initial begin
        int plots, starts, dones, waited;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_x", x_out, 8'd0);
        check("rst_y", y_out, 7'd0);
        check("rst_col", colour, 3'd0);
        check("rst_plot", plot, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        resetn = 1'b1;
        @(negedge clk);

        // 1: same row as reset old_y -> draw only
        y_coordinate = 7'd60;
        tick_pulse();
        check("t1_busy_k", busy, 1'b0);
        frame_body(1'b0, 7'd60, 7'd60);
        idle_check();

        // 2: move to 70 -> erase 60..63 then draw 70..73
        y_coordinate = 7'd70;
        tick_pulse();
        frame_body(1'b1, 7'd60, 7'd70);
        idle_check();

        // 3: clamp 121 -> 116
        y_coordinate = 7'd121;
        tick_pulse();
        frame_body(1'b1, 7'd70, 7'd116);
        idle_check();

        // 4: old_y must now be 116 (no erase); three ticks while busy -> one extra frame
        y_coordinate = 7'd116;
        tick_pulse();
        fork
            frame_body(1'b0, 7'd116, 7'd116);
            begin
                repeat (3) begin
                    @(negedge clk) tick = 1'b1;
                    @(negedge clk) tick = 1'b0;
                end
                y_coordinate = 7'd30;
            end
        join
        frame_body(1'b1, 7'd116, 7'd30);
        idle_check();
        idle_check();

        // 5: async reset mid-erase restores old_y=60
        y_coordinate = 7'd50;
        tick_pulse();
        repeat (6) @(negedge clk);
        check("t5_plot_pre", plot, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("t5_plot_rst", plot, 1'b0);
        check("t5_busy_rst", busy, 1'b0);
        check("t5_x_rst", x_out, 8'd0);
        @(negedge clk) resetn = 1'b1;
        idle_check();
        y_coordinate = 7'd60;
        tick_pulse();
        frame_body(1'b0, 7'd60, 7'd60);
        idle_check();

        // 6: random soak
        plots = 0;
        starts = 0;
        dones = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (plot) begin
                plots++;
                check("rnd_x", ((x_out >= 8'd20) && (x_out <= 8'd23)), 1'b1);
                check("rnd_ymax", (y_out <= 7'd119), 1'b1);
            end
            if (busy && !plot && !done) starts++;
            if (done) begin
                dones++;
                check("rnd_npix", ((plots == 16) || (plots == 32)), 1'b1);
                plots = 0;
            end
            tick = ($urandom_range(0, 19) == 0);
            y_coordinate = 7'($urandom_range(0, 127));
        end
        @(negedge clk) tick = 1'b0;
        waited = 0;
        while ((busy || done) && waited < 200) begin
            if (busy && !plot && !done) starts++;
            if (done) begin
                dones++;
                check("rnd_npix_tail", ((plots == 16) || (plots == 32)), 1'b1);
                plots = 0;
            end
            if (plot) plots++;
            @(negedge clk);
            waited++;
        end
        check("rnd_drain", (waited < 200), 1'b1);
        check("rnd_frames", dones, starts);
        check("rnd_some", (starts > 10), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
